// File: rtl/ldst_dmem_responder.sv
// Data-memory responder for the load-store unit: one outstanding byte/half/word
// access on an internal little-endian word RAM, fixed-latency valid/ready response.
// Optional feature: define QU_DMEM_ALIGN_CHECK_EN to flag misaligned accesses
// through resp_err instead of force-aligning them.
module ldst_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned TAG_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [31:0]        mem [DEPTH_WORDS] = '{default: '0};

  logic               accept;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         off;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic [31:0]        rd_word;
  logic [31:0]        shifted;
  logic [31:0]        load_data;
  logic               drop;
  logic               wr_en;
  logic [31:0]        rdata_next;
  logic               unused_addr_hi;

  assign req_ready      = (state == S_IDLE) && !rst;
  assign accept         = req_valid && req_ready;
  assign idx            = req_addr[IDX_W+1:2];
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

  // Lane offset: narrow accesses are force-aligned to their natural boundary
  always_comb begin
    off = 2'b00;
    case (req_size)
      2'b00:   off = req_addr[1:0];
      2'b01:   off = {req_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

`ifdef QU_DMEM_ALIGN_CHECK_EN
  assign drop = ((req_size == 2'b01) && req_addr[0]) ||
                (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign drop = 1'b0;
`endif

  // Byte enables and replicated store lanes
  always_comb begin
    be     = 4'b1111;
    wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        be     = 4'(4'b0001 << off);
        wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection and sign/zero extension of the read word
  always_comb begin
    rd_word   = mem[idx];
    shifted   = rd_word >> {off, 3'b000};
    load_data = shifted;
    case (req_size)
      2'b00:   load_data = {{24{!req_unsigned && shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{!req_unsigned && shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
    rdata_next = (req_we || drop) ? 32'h0 : load_data;
  end

  assign wr_en = accept && req_we && !drop;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
    end
  end

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      resp_valid <= (state_next == S_RESP);
    end
  end

  // Next-state logic: IDLE -> WAIT (counting) -> RESP -> IDLE
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Response payload captured at acceptance and held until the next request
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_tag   <= '0;
    end else if (accept) begin
      resp_rdata <= rdata_next;
      resp_tag   <= req_tag;
    end
  end

`ifdef QU_DMEM_ALIGN_CHECK_EN
  // Misalignment flag registered alongside the payload
  always_ff @(posedge clk) begin
    if (rst)         resp_err <= 1'b0;
    else if (accept) resp_err <= drop;
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldst_dmem_responder.sv
// Directed bench for ldst_dmem_responder with default parameters (LATENCY = 2).
module tb_ldst_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [5:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [5:0]  resp_tag;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ldst_dmem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_tag(resp_tag), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete request/response; drives at #1 after a rising edge
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input logic [5:0] tag,
                     output logic [31:0] rd, output logic er, output logic [5:0] tg);
    int lat;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    rd = resp_rdata; er = resp_err; tg = resp_tag;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("valid_drop", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  task automatic load(input string name, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [5:0] tag,
                      input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd; logic er; logic [5:0] tg;
    txn(1'b0, addr, 32'h0, size, uns, tag, rd, er, tg);
    chk(name, rd, exp);
    chk({name, "_tag"}, 32'(tg), 32'(tag));
    chk({name, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic store(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic [5:0] tag, input logic exp_err);
    logic [31:0] rd; logic er; logic [5:0] tg;
    txn(1'b1, addr, wdata, size, 1'b0, tag, rd, er, tg);
    chk({name, "_rdata"}, rd, 32'h0);
    chk({name, "_tag"}, 32'(tg), 32'(tag));
    chk({name, "_err"}, 32'(er), 32'(exp_err));
  endtask

  logic        align_err;
  logic [31:0] mis_word_exp;
  logic [31:0] mis_store_exp;

  initial begin
`ifdef QU_DMEM_ALIGN_CHECK_EN
    align_err     = 1'b1;
    mis_word_exp  = 32'h0;
    mis_store_exp = 32'h123455EF;
`else
    align_err     = 1'b0;
    mis_word_exp  = 32'h123455EF;
    mis_store_exp = 32'h12349999;
`endif
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0; req_tag = '0; resp_ready = 1'b0;

    // Reset for two cycles
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst_req_ready2", 32'(req_ready), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_tag", 32'(resp_tag), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    load("init_zero", 32'h40, 2'b10, 1'b0, 6'd1, 32'h0, 1'b0);
    store("st_word", 32'h10, 32'hDEADBEEF, 2'b10, 6'd3, 1'b0);
    load("ld_word", 32'h10, 2'b10, 1'b0, 6'd5, 32'hDEADBEEF, 1'b0);
    load("ld_b13_s", 32'h13, 2'b00, 1'b0, 6'd6, 32'hFFFFFFDE, 1'b0);
    load("ld_b13_u", 32'h13, 2'b00, 1'b1, 6'd7, 32'h000000DE, 1'b0);
    load("ld_h10_s", 32'h10, 2'b01, 1'b0, 6'd8, 32'hFFFFBEEF, 1'b0);
    load("ld_h12_u", 32'h12, 2'b01, 1'b1, 6'd9, 32'h0000DEAD, 1'b0);
    load("ld_h12_s", 32'h12, 2'b01, 1'b0, 6'd10, 32'hFFFFDEAD, 1'b0);
    store("st_b11", 32'h11, 32'hAABBCC55, 2'b00, 6'd11, 1'b0);
    load("ld_after_b", 32'h10, 2'b10, 1'b0, 6'd12, 32'hDEAD55EF, 1'b0);
    store("st_h12", 32'h12, 32'hFFFF1234, 2'b01, 6'd13, 1'b0);
    load("ld_after_h", 32'h10, 2'b10, 1'b0, 6'd14, 32'h123455EF, 1'b0);
    load("ld_alias", 32'h1010, 2'b11, 1'b0, 6'd15, 32'h123455EF, 1'b0);

    // Backpressure: hold the response, with a stray store that must be ignored
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_tag = 6'd21;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'h0BADF00D; req_tag = 6'd40;
    @(posedge clk); #1;
    chk("bp_valid_rise", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'h123455EF);
      chk("bp_tag", 32'(resp_tag), 32'd21);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    load("ld_after_bp", 32'h10, 2'b10, 1'b0, 6'd22, 32'h123455EF, 1'b0);

    // Misaligned accesses
    load("mis_word", 32'h12, 2'b10, 1'b0, 6'd23, mis_word_exp, align_err);
    store("mis_half_st", 32'h11, 32'h00009999, 2'b01, 6'd24, align_err);
    load("mis_st_chk", 32'h10, 2'b10, 1'b0, 6'd25, mis_store_exp, 1'b0);

    // Reset mid-operation: response discarded, store stays committed
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    req_size = 2'b10; req_tag = 6'd30;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_tag", 32'(resp_tag), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    load("ld_after_rst", 32'h20, 2'b10, 1'b0, 6'd31, 32'hCAFEF00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldst_dmem_responder.md
# ldst_dmem_responder

Data-memory responder that services requests issued by the load-store unit once it has formed the effective address (opd1 + opd2). It accepts one load or store at a time through a valid/ready request channel and performs a little-endian byte, half or word access on an internal word-organised RAM. It returns read data, sign- or zero-extended, plus a pass-through tag on a valid/ready response channel after a fixed latency. It sits between `ldst_unit` and the core's writeback/commit logic and serves as the team's behavioural data memory for simulation and small FPGA builds.

## Interface
Reset is synchronous and active-high on `rst`; `clk` is the only clock.

Parameters:
- `DEPTH_WORDS`, 1024, RAM size in 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2, cycles from request acceptance to `resp_valid`; ≥ 1.
- `TAG_W`, 6, width of the pass-through tag.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address from `ldst_unit.addr_out`
- `req_wdata`  in  32  store data; the low bytes are used for narrow stores
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_tag`  in  TAG_W  returned unchanged on `resp_tag`
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts response
- `resp_rdata`  out  32  load data (0 for stores and errors)
- `resp_tag`  out  TAG_W  tag of the request being answered
- `resp_err`  out  1  misaligned access (see Configuration)

## Operation
- **IDLE:**
  - `req_ready` = 1 (0 while `rst` = 1).
  - A handshake (`req_valid` && `req_ready`) moves the block to WAIT, or straight to RESP when `LATENCY` = 1.
- **WAIT:**
  - A down-counter is loaded with `LATENCY-1` at acceptance and decrements each cycle.
  - The block moves to RESP when the counter reaches 0.
- **RESP:**
  - `resp_valid` = 1 and all response fields are held stable.
  - The block returns to IDLE on the edge where `resp_ready` = 1.
- At most one request is outstanding, so there is no request/response overlap.
- **Word index:** `req_addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses alias modulo `DEPTH_WORDS*4`.
- **Store:**
  - Committed to the RAM on the acceptance edge, with byte enables from `req_size` and `req_addr[1:0]`.
  - Byte store writes lane `addr[1:0]`; half store writes lanes `{addr[1],0}` and `{addr[1],1}`.
  - Response has `resp_rdata` = 0.
- **Load:**
  - The word is read on the acceptance edge.
  - Lane selection and extension are applied, and the result is registered into `resp_rdata`.
- **Misaligned:** half with `addr[0]`=1, or word with `addr[1:0]`≠0. Handling depends on `QU_DMEM_ALIGN_CHECK_EN`.
- RAM contents are not affected by reset and are initialised to 0 at time zero.

## Timing
- Request accepted at edge T → `resp_valid` rises after edge T+LATENCY-1, so it is visible in cycle T+LATENCY.
- `resp_valid` stays high, with fields stable, until the edge where `resp_ready` = 1.
- Response handshake at edge R → `req_ready` = 1 in the cycle after R.
- Back-to-back throughput is one request per `LATENCY`+1 cycles when `resp_ready` is held high.
- `resp_ready` held low stalls indefinitely in RESP; no data is lost.
- **Reset values:**
  - State IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_tag` 0, `resp_err` 0.
  - `req_ready` is 0 during the reset cycle and 1 afterwards.
- **Reset mid-operation:**
  - Any pending response is discarded.
  - A store accepted before reset stays committed.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- **`QU_DMEM_ALIGN_CHECK_EN` defined:**
  - A misaligned access writes nothing.
  - It responds with `resp_err` = 1 and `resp_rdata` = 0 after the normal latency, with the tag preserved.
- **Not defined:**
  - `resp_err` is tied to 0.
  - The address is force-aligned: half clears bit 0, word clears bits 1:0.
  - The access then proceeds normally.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs at reset values, `req_ready` = 0 during reset and 1 after.
- **Word store/load, `LATENCY`=2:**
  - Store 0xDEADBEEF to 0x10, tag 3 → `resp_valid` 2 cycles after acceptance, tag 3, rdata 0.
  - Word load from 0x10 → 0xDEADBEEF.
- **Sub-word loads, memory word at 0x10 = 0xDEADBEEF:**
  - Byte load 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE.
  - Half load 0x10 signed → 0xFFFFBEEF.
- **Byte store:** byte store 0x55 to 0x11, then word load 0x10 → 0xDEAD55EF.
- **Backpressure:**
  - Hold `resp_ready` = 0 for 5 cycles → `resp_valid` and fields are stable and `req_ready` = 0 throughout.
  - Release → `req_ready` = 1 on the next cycle.
- **Misaligned word load at 0x12:**
  - With the macro → `resp_err` = 1, rdata 0.
  - Without it → data from 0x10, `resp_err` = 0.
